// File: rtl/debug_unit_sequencer_if.sv
// Debug-unit bundle: UART byte handshake plus the core-side debug taps
// (run control, register-file read port, instruction-memory write port).
interface debug_unit_sequencer_if #(
    parameter int BYTE    = 8,
    parameter int DWORD   = 32,
    parameter int ADDR    = 7,
    parameter int RB_ADDR = 5
);
    logic [BYTE-1:0]    i_rx_data;
    logic               i_rx_done;
    logic [BYTE-1:0]    o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_cpu_enable;
    logic               i_halt;
    logic [DWORD-1:0]   i_pc;
    logic [RB_ADDR-1:0] o_rf_addr;
    logic [DWORD-1:0]   i_rf_data;
    logic               o_im_we;
    logic [ADDR-1:0]    o_im_addr;
    logic [BYTE-1:0]    o_im_data;

    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc, i_rf_data,
        output o_tx_data, o_tx_start, o_cpu_enable, o_rf_addr,
               o_im_we, o_im_addr, o_im_data
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_halt, i_pc, i_rf_data,
        input  o_tx_data, o_tx_start, o_cpu_enable, o_rf_addr,
               o_im_we, o_im_addr, o_im_data
    );
endinterface

// File: rtl/debug_unit_sequencer.sv
// UART command sequencer for the MIPS core: program load, run/step control
// and a 132-byte PC + register-file dump back over TX.
module debug_unit_sequencer #(
    parameter int BYTE    = 8,
    parameter int DWORD   = 32,
    parameter int ADDR    = 7,
    parameter int RB_ADDR = 5
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    debug_unit_sequencer_if.master  bus
);
    localparam int LEN_W = BYTE + 2;
    localparam logic [BYTE-1:0] CMD_LOAD = BYTE'(8'h01);
    localparam logic [BYTE-1:0] CMD_RUN  = BYTE'(8'h03);
    localparam logic [BYTE-1:0] CMD_STEP = BYTE'(8'h07);
    localparam logic [BYTE-1:0] CMD_DUMP = BYTE'(8'h08);
    localparam logic [BYTE-1:0] ACK_BYTE = BYTE'(8'hA5);
    localparam logic [BYTE-1:0] ERR_BYTE = BYTE'(8'hFF);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD_LEN, ST_LOAD_BYTE, ST_ACK, ST_RUN, ST_STEP,
        ST_DUMP_SEL, ST_DUMP_SEND, ST_DUMP_WAIT, ST_ERR
    } state_t;

    state_t             state_reg, state_next;
    logic               halted_reg, halted_next;
    logic [ADDR-1:0]    addr_cnt_reg, addr_cnt_next;
    logic [LEN_W-1:0]   rem_reg, rem_next;
    logic [DWORD-1:0]   word_reg, word_next;
    logic [1:0]         byte_idx_reg, byte_idx_next;
    logic               pc_phase_reg, pc_phase_next;
    logic               step_flag_reg, step_flag_next;
    logic               sel_wait_reg, sel_wait_next;
    logic [BYTE-1:0]    tx_data_reg, tx_data_next;
    logic               tx_start_reg, tx_start_next;
    logic               cpu_en_reg, cpu_en_next;
    logic [RB_ADDR-1:0] rf_addr_reg, rf_addr_next;
    logic               im_we_reg, im_we_next;
    logic [ADDR-1:0]    im_addr_reg, im_addr_next;
    logic [BYTE-1:0]    im_data_reg, im_data_next;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_reg     <= ST_IDLE;
            halted_reg    <= 1'b0;
            addr_cnt_reg  <= '0;
            rem_reg       <= '0;
            word_reg      <= '0;
            byte_idx_reg  <= '0;
            pc_phase_reg  <= 1'b0;
            step_flag_reg <= 1'b0;
            sel_wait_reg  <= 1'b0;
            tx_data_reg   <= '0;
            tx_start_reg  <= 1'b0;
            cpu_en_reg    <= 1'b0;
            rf_addr_reg   <= '0;
            im_we_reg     <= 1'b0;
            im_addr_reg   <= '0;
            im_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            halted_reg    <= halted_next;
            addr_cnt_reg  <= addr_cnt_next;
            rem_reg       <= rem_next;
            word_reg      <= word_next;
            byte_idx_reg  <= byte_idx_next;
            pc_phase_reg  <= pc_phase_next;
            step_flag_reg <= step_flag_next;
            sel_wait_reg  <= sel_wait_next;
            tx_data_reg   <= tx_data_next;
            tx_start_reg  <= tx_start_next;
            cpu_en_reg    <= cpu_en_next;
            rf_addr_reg   <= rf_addr_next;
            im_we_reg     <= im_we_next;
            im_addr_reg   <= im_addr_next;
            im_data_reg   <= im_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        halted_next    = halted_reg;
        addr_cnt_next  = addr_cnt_reg;
        rem_next       = rem_reg;
        word_next      = word_reg;
        byte_idx_next  = byte_idx_reg;
        pc_phase_next  = pc_phase_reg;
        step_flag_next = step_flag_reg;
        sel_wait_next  = sel_wait_reg;
        tx_data_next   = tx_data_reg;
        tx_start_next  = 1'b0;
        cpu_en_next    = cpu_en_reg;
        rf_addr_next   = rf_addr_reg;
        im_we_next     = 1'b0;
        im_addr_next   = im_addr_reg;
        im_data_next   = im_data_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == CMD_LOAD) begin
                        addr_cnt_next = '0;
                        state_next    = ST_LOAD_LEN;
                    end else if (bus.i_rx_data == CMD_RUN || bus.i_rx_data == CMD_STEP) begin
                        if (halted_reg) begin
                            tx_data_next  = ERR_BYTE;
                            tx_start_next = 1'b1;
                            state_next    = ST_ERR;
                        end else begin
                            cpu_en_next    = 1'b1;
                            step_flag_next = (bus.i_rx_data == CMD_STEP);
                            state_next     = (bus.i_rx_data == CMD_STEP) ? ST_STEP : ST_RUN;
                        end
                    end else if (bus.i_rx_data == CMD_DUMP) begin
                        pc_phase_next  = 1'b1;
                        step_flag_next = 1'b0;
                        state_next     = ST_DUMP_SEL;
                    end
                end
            end
            ST_LOAD_LEN: begin
                if (bus.i_rx_done) begin
                    rem_next   = {bus.i_rx_data, 2'b00};
                    state_next = (bus.i_rx_data == '0) ? ST_IDLE : ST_LOAD_BYTE;
                end
            end
            ST_LOAD_BYTE: begin
                if (bus.i_rx_done) begin
                    im_we_next    = 1'b1;
                    im_addr_next  = addr_cnt_reg;
                    im_data_next  = bus.i_rx_data;
                    addr_cnt_next = addr_cnt_reg + 1'b1;
                    rem_next      = rem_reg - 1'b1;
                    if (rem_reg == LEN_W'(1)) begin
                        halted_next   = 1'b0;
                        tx_data_next  = ACK_BYTE;
                        tx_start_next = 1'b1;
                        state_next    = ST_ACK;
                    end
                end
            end
            ST_ACK, ST_ERR: begin
                if (bus.i_tx_done) state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.i_halt) begin
                    cpu_en_next   = 1'b0;
                    halted_next   = 1'b1;
                    pc_phase_next = 1'b1;
                    state_next    = ST_DUMP_SEL;
                end
            end
            ST_STEP: begin
                cpu_en_next   = 1'b0;
                pc_phase_next = 1'b1;
                state_next    = ST_DUMP_SEL;
            end
            ST_DUMP_SEL: begin
                // PC and the post-step halt level are sampled one cycle after the core stopped.
                if (pc_phase_reg) begin
                    word_next = bus.i_pc;
                    if (step_flag_reg && bus.i_halt) halted_next = 1'b1;
                    step_flag_next = 1'b0;
                    state_next     = ST_DUMP_SEND;
                end else if (!sel_wait_reg) begin
                    sel_wait_next = 1'b1;
                end else begin
                    word_next     = bus.i_rf_data;
                    sel_wait_next = 1'b0;
                    state_next    = ST_DUMP_SEND;
                end
            end
            ST_DUMP_SEND: begin
                tx_data_next  = word_reg[DWORD-1 -: BYTE];
                tx_start_next = 1'b1;
                word_next     = word_reg << BYTE;
                state_next    = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (bus.i_tx_done) begin
                    byte_idx_next = byte_idx_reg + 1'b1;
                    if (byte_idx_reg != 2'd3) begin
                        state_next = ST_DUMP_SEND;
                    end else if (pc_phase_reg) begin
                        pc_phase_next = 1'b0;
                        rf_addr_next  = '0;
                        state_next    = ST_DUMP_SEL;
                    end else if (rf_addr_reg == '1) begin
                        rf_addr_next = '0;
                        state_next   = ST_IDLE;
                    end else begin
                        rf_addr_next = rf_addr_reg + 1'b1;
                        state_next   = ST_DUMP_SEL;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.o_tx_data    = tx_data_reg;
    assign bus.o_tx_start   = tx_start_reg;
    assign bus.o_cpu_enable = cpu_en_reg;
    assign bus.o_rf_addr    = rf_addr_reg;
    assign bus.o_im_we      = im_we_reg;
    assign bus.o_im_addr    = im_addr_reg;
    assign bus.o_im_data    = im_data_reg;
endmodule
